// File: rtl/ext_code_loader.sv
// ext_code_loader: framed host byte stream -> shadow code buffer -> clear + SET_FLAG/SET_DATA replay.
// Define LOADER_CHKSUM_EN to build the trailing checksum byte and CHK state.
module ext_code_loader #(
   parameter int DEPTH   = 8,
   parameter int SET_GAP = 2,
   parameter int TIMEOUT = 100000
) (
   input  logic        iClk,
   input  logic        iRst_n,
   input  logic [7:0]  iByte,
   input  logic        iByteValid,
   output logic        oByteReady,
   output logic        oTblRst,
   output logic        oSET_FLAG,
   output logic [31:0] oSET_DATA,
   output logic        oBusy,
   output logic        oDone,
   output logic        oErr,
   output logic [1:0]  oErrCode
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int GW = (SET_GAP > 1) ? $clog2(SET_GAP) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [7:0] HDR = 8'hA5;

   typedef enum logic [3:0] {
      S_IDLE, S_CNT, S_DATA, S_CHK, S_CLR, S_SETUP, S_PULSE, S_HOLD, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] last_q, last_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [1:0]    bcnt_q, bcnt_d;
   logic [23:0]   asm_q, asm_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [TW-1:0] to_q, to_d;
   logic [31:0]   shadow_q [DEPTH];
   logic          shadow_we;
   logic [31:0]   shadow_wdata;
   logic          xfer;
`ifdef LOADER_CHKSUM_EN
   logic [7:0]    chk_q, chk_d;
`endif

   logic          rdy_q, rdy_d;
   logic          tblrst_q, tblrst_d;
   logic          flag_q, flag_d;
   logic [31:0]   data_q, data_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [1:0]    code_q, code_d;

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      idx_d        = idx_q;
      bcnt_d       = bcnt_q;
      asm_d        = asm_q;
      gap_d        = gap_q;
      to_d         = to_q;
      shadow_we    = 1'b0;
      shadow_wdata = {iByte, asm_q};
      err_d        = 1'b0;
      code_d       = code_q;
      data_d       = data_q;
      xfer         = iByteValid && rdy_q;
`ifdef LOADER_CHKSUM_EN
      chk_d        = chk_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (xfer && iByte == HDR) state_d = S_CNT;
         end
         S_CNT: begin
            if (xfer) begin
               if (iByte == 8'd0 || iByte > 8'(DEPTH)) begin
                  err_d   = 1'b1;
                  code_d  = 2'd1;
                  state_d = S_IDLE;
               end else begin
                  last_d  = IW'(iByte - 8'd1);
                  idx_d   = '0;
                  bcnt_d  = '0;
`ifdef LOADER_CHKSUM_EN
                  chk_d   = iByte;
`endif
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               // Bytes arrive LSB first, so each one shifts in from the top.
               asm_d  = {iByte, asm_q[23:8]};
               bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHKSUM_EN
               chk_d  = chk_q ^ iByte;
`endif
               if (bcnt_q == 2'd3) begin
                  shadow_we = 1'b1;
                  idx_d     = idx_q + 1'b1;
                  if (idx_q == last_q) begin
`ifdef LOADER_CHKSUM_EN
                     state_d = S_CHK;
`else
                     state_d = S_CLR;
`endif
                  end
               end
            end
         end
`ifdef LOADER_CHKSUM_EN
         S_CHK: begin
            if (xfer) begin
               if (iByte != chk_q) begin
                  err_d   = 1'b1;
                  code_d  = 2'd2;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_CLR;
               end
            end
         end
`endif
         S_CLR: begin
            idx_d   = '0;
            gap_d   = '0;
            state_d = S_SETUP;
         end
         S_SETUP: begin
            if (gap_q == GW'(SET_GAP - 1)) begin
               gap_d   = '0;
               state_d = S_PULSE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         S_PULSE: begin
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (gap_q == GW'(SET_GAP - 1)) begin
               gap_d = '0;
               if (idx_q == last_q) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_SETUP;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Inter-byte watchdog only while a frame is being received.
      if (state_q == S_CNT || state_q == S_DATA || state_q == S_CHK) begin
         if (xfer) begin
            to_d = '0;
         end else begin
            if (to_q != '1) to_d = to_q + 1'b1;
            if (TIMEOUT != 0 && to_d == TW'(TIMEOUT)) begin
               err_d   = 1'b1;
               code_d  = 2'd3;
               state_d = S_IDLE;
            end
         end
      end else begin
         to_d = '0;
      end

      rdy_d    = (state_d == S_IDLE) || (state_d == S_CNT) ||
                 (state_d == S_DATA) || (state_d == S_CHK);
      busy_d   = !((state_d == S_IDLE) || (state_d == S_DONE));
      tblrst_d = (state_d == S_CLR);
      flag_d   = (state_d == S_PULSE);
      done_d   = (state_d == S_DONE);
      if (state_d == S_SETUP) begin
         data_d = shadow_q[idx_d];
      end else if (state_d == S_DONE) begin
         data_d = '0;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state_q  <= S_IDLE;
         last_q   <= '0;
         idx_q    <= '0;
         bcnt_q   <= '0;
         gap_q    <= '0;
         to_q     <= '0;
         rdy_q    <= 1'b0;
         tblrst_q <= 1'b0;
         flag_q   <= 1'b0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         idx_q    <= idx_d;
         bcnt_q   <= bcnt_d;
         gap_q    <= gap_d;
         to_q     <= to_d;
         rdy_q    <= rdy_d;
         tblrst_q <= tblrst_d;
         flag_q   <= flag_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         code_q   <= code_d;
      end
   end

   // Frame payload storage carries no reset; a new frame always overwrites it.
   always_ff @(posedge iClk) begin
      asm_q <= asm_d;
      if (shadow_we) shadow_q[idx_q] <= shadow_wdata;
`ifdef LOADER_CHKSUM_EN
      chk_q <= chk_d;
`endif
   end

   assign oByteReady = rdy_q;
   assign oTblRst    = tblrst_q;
   assign oSET_FLAG  = flag_q;
   assign oSET_DATA  = data_q;
   assign oBusy      = busy_q;
   assign oDone      = done_q;
   assign oErr       = err_q;
   assign oErrCode   = code_q;
endmodule
